// File: rtl/maze_pkg.sv
// ============================================================================
// maze_pkg : shared maze types for the solver back-end (coordinates, moves, FSM)
// Revision : 1.0
// ============================================================================
`default_nettype none

package maze_pkg;

  localparam int MAZE_DIM = 15;

  typedef logic [3:0] coord_t;

  typedef enum logic [1:0] {
    DIR_XP = 2'd0,
    DIR_YP = 2'd1,
    DIR_XN = 2'd2,
    DIR_YN = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    FIN     = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/path_move_encoder_if.sv
// ============================================================================
// path_move_encoder_if : solver path input, move stream and per-path status
// Revision : 1.0
// ============================================================================
`default_nettype none

interface path_move_encoder_if #(
  parameter int CW = 4
);
  logic          in_valid;
  logic          in_not_valid;
  logic [CW-1:0] in_x;
  logic [CW-1:0] in_y;
  logic          mv_valid;
  logic          mv_ready;
  logic [1:0]    mv_dir;
  logic          mv_last;
  logic [CW-1:0] origin_x;
  logic [CW-1:0] origin_y;
  logic [7:0]    path_len;
  logic          no_path;
  logic          err;
  logic          done;
  logic          busy;

  modport master (
    output in_valid, in_not_valid, in_x, in_y, mv_ready,
    input  mv_valid, mv_dir, mv_last, origin_x, origin_y, path_len,
           no_path, err, done, busy
  );

  modport slave (
    input  in_valid, in_not_valid, in_x, in_y, mv_ready,
    output mv_valid, mv_dir, mv_last, origin_x, origin_y, path_len,
           no_path, err, done, busy
  );
endinterface

`default_nettype wire

// File: rtl/path_fifo.sv
// ============================================================================
// path_fifo : synchronous FIFO with occupancy count and full/empty flags
// Revision : 1.0
// ============================================================================
`default_nettype none

module path_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/path_move_encoder.sv
// ============================================================================
// path_move_encoder : converts the solver's coordinate stream into buffered
//                     2-bit move codes with per-path origin/length/error status
// Revision : 1.0
// ============================================================================
`default_nettype none

module path_move_encoder
  import maze_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  path_move_encoder_if.slave  bus
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic signed [CW:0] STEP_POS = (CW+1)'(1);
  localparam logic signed [CW:0] STEP_NEG = '1;

  state_e            state;
  state_e            state_nx;
  logic [CW-1:0]     prev_x;
  logic [CW-1:0]     prev_y;
  logic signed [CW:0] dx;
  logic signed [CW:0] dy;
  logic              step_ok;
  dir_e              step_dir;
  logic              push;
  logic              pop;
  logic [1:0]        head;
  logic [CNTW-1:0]   count;
  logic              full;
  logic              empty;

  assign dx = {1'b0, bus.in_x} - {1'b0, prev_x};
  assign dy = {1'b0, bus.in_y} - {1'b0, prev_y};

  // A legal step moves exactly one cell along exactly one axis.
  always_comb begin
    step_ok  = 1'b0;
    step_dir = DIR_XP;
    if (dy == '0) begin
      if (dx == STEP_POS) begin
        step_ok  = 1'b1;
        step_dir = DIR_XP;
      end else if (dx == STEP_NEG) begin
        step_ok  = 1'b1;
        step_dir = DIR_XN;
      end
    end else if (dx == '0) begin
      if (dy == STEP_POS) begin
        step_ok  = 1'b1;
        step_dir = DIR_YP;
      end else if (dy == STEP_NEG) begin
        step_ok  = 1'b1;
        step_dir = DIR_YN;
      end
    end
  end

  assign push = (state == COLLECT) && bus.in_valid && step_ok && !full;
  assign pop  = bus.mv_valid && bus.mv_ready;

  path_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2),
    .CNTW  (CNTW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (step_dir),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // While collecting, the newest move is held back so mv_last can be exact.
  always_comb begin
    state_nx     = state;
    bus.mv_valid = 1'b0;
    bus.mv_last  = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = (state != IDLE);
    bus.mv_dir   = head;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nx = bus.in_not_valid ? FIN : COLLECT;
        end
      end
      COLLECT: begin
        bus.mv_valid = (count >= CNTW'(2));
        if (!bus.in_valid) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        bus.mv_valid = !empty;
        bus.mv_last  = (count == CNTW'(1));
        if (empty) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_x       <= '0;
      prev_y       <= '0;
      bus.origin_x <= '0;
      bus.origin_y <= '0;
      bus.path_len <= '0;
      bus.no_path  <= 1'b0;
      bus.err      <= 1'b0;
    end else if (bus.in_valid) begin
      case (state)
        IDLE: begin
          bus.err      <= 1'b0;
          bus.path_len <= '0;
          if (bus.in_not_valid) begin
            bus.no_path <= 1'b1;
          end else begin
            bus.no_path  <= 1'b0;
            bus.origin_x <= bus.in_x;
            bus.origin_y <= bus.in_y;
            prev_x       <= bus.in_x;
            prev_y       <= bus.in_y;
          end
        end
        COLLECT: begin
          prev_x <= bus.in_x;
          prev_y <= bus.in_y;
          if (!step_ok || full) begin
            bus.err <= 1'b1;
          end else if (bus.path_len != 8'hFF) begin
            bus.path_len <= bus.path_len + 8'd1;
          end
        end
        default: bus.err <= 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire
